// File: rtl/gate_op_scheduler.sv
// gate_op_scheduler: two-requester round-robin front end feeding one shared
// 1-bit gate unit that evaluates a bitwise gate operation serially, LSB first.
// Handshakes: gnt is a one-cycle pulse in IDLE naming the requester whose
// op/operands are latched that cycle; res_valid stays high in DONE until
// res_ready is sampled high, and the transfer completes on that edge.
module gate_op_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic             r_id;
    logic             r_busy;
    logic             r_valid;

    logic             w_req_any;
    logic             w_win;
    logic             w_grant;
    logic [2:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_illegal;
    logic             w_abit;
    logic             w_bbit;
    logic             w_or;
    logic             w_and;
    logic             w_xor;
    logic             w_base;
    logic             w_inv;
    logic             w_gate;

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        w_req_any = |req;
        w_win     = (req == 2'b11) ? ~r_last : req[1];
        w_grant   = (r_state == S_IDLE) && w_req_any && !rst;
        gnt       = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;
        w_sel_op  = w_win ? op1 : op0;
        w_sel_a   = w_win ? a1 : a0;
        w_sel_b   = w_win ? b1 : b0;
        w_illegal = w_sel_op[2] & w_sel_op[1];
    end

    // Shared 1-bit gate: OR/AND/XOR from 2:1 muxes on a, optional inversion.
    always_comb begin
        w_abit = r_a[r_cnt];
        w_bbit = r_b[r_cnt];
        w_or   = w_abit ? 1'b1 : w_bbit;
        w_and  = w_abit ? w_bbit : 1'b0;
        w_xor  = w_abit ? ~w_bbit : w_bbit;
        // ops 0/3 use OR, 1/2 use AND, 4/5 use XOR; 2, 3 and 5 are inverted
        w_base = r_op[2] ? w_xor : ((r_op[1] ^ r_op[0]) ? w_and : w_or);
        w_inv  = r_op[2] ? r_op[0] : r_op[1];
        w_gate = w_inv ? ~w_base : w_base;
    end

    // Control FSM with its datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_id     <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_last   <= w_win;
                        r_id     <= w_win;
                        r_op     <= w_sel_op;
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_cnt    <= '0;
                        // cleared here so no stale bits show during RUN
                        r_result <= '0;
                        r_err    <= w_illegal;
                        r_busy   <= 1'b1;
                        r_valid  <= w_illegal;
                        r_state  <= w_illegal ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[r_cnt] <= w_gate;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign res_valid = r_valid;
    assign res_id    = r_id;
    assign result    = r_result;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Bench for gate_op_scheduler: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_gate_op_scheduler;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [2:0]       op0, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             res_ready;
    logic [1:0]       gnt;
    logic             busy, res_valid, res_id, err;
    logic [WIDTH-1:0] result;
    logic [1:0]       dbg_state;

    gate_op_scheduler #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .result(result), .err(err), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // counters and scoreboard
    int n_chk = 0;
    int n_pass = 0;
    logic [WIDTH+1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // reference model: whole-word gate functions and transaction phases
    function automatic logic [WIDTH-1:0] gate_word(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            3'd0: return a | b;
            3'd1: return a & b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    function automatic logic winner(input logic [1:0] r, input logic last);
        if (r == 2'b11) return !last;
        return r[1];
    endfunction

    int               m_phase = 0;   // 0 waiting, 1 computing, 2 holding result
    int               m_k = 0;       // result bits produced so far
    logic [WIDTH-1:0] m_full = '0;
    logic             m_err = 1'b0;
    logic             m_id = 1'b0;
    logic             m_last = 1'b1;
    bit               m_clean = 1'b1;
    int               m_granted = -1;

    // observations used by directed checks
    int          cyc = 0;
    int          last_gnt_cyc = 0;
    int          rise_cyc = 0;
    bit          seen_rise = 1'b0;
    logic        prev_valid = 1'b0;
    logic [1:0]       gnt_q[$];
    logic [WIDTH-1:0] res_q[$];

    task automatic check_outputs();
        logic [1:0]       eg;
        logic [WIDTH-1:0] mask;
        logic [WIDTH+1:0] e;
        eg = 2'b00;
        if (!rst && m_phase == 0 && req != 2'b00)
            eg = winner(req, m_last) ? 2'b10 : 2'b01;
        chk("gnt", gnt, eg);
        chk("busy", busy, m_phase != 0);
        chk("res_valid", res_valid, m_phase == 2);
        if (m_phase != 0) begin
            mask = '0;
            for (int j = 0; j < WIDTH; j++) mask[j] = (m_phase == 2) || (j < m_k);
            chk("result", result, m_full & mask);
            chk("res_id", res_id, m_id);
            chk("err", err, m_err);
        end else if (m_clean) begin
            chk("result_clr", result, 0);
            chk("err_clr", err, 0);
            chk("res_id_clr", res_id, 0);
        end
        cyc++;
        if (gnt != 2'b00) begin
            gnt_q.push_back(gnt);
            last_gnt_cyc = cyc;
        end
        if (res_valid && !prev_valid) begin
            rise_cyc  = cyc;
            seen_rise = 1'b1;
            res_q.push_back(result);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_txn", {res_id, err, result}, e);
            end else begin
                chk("sb_unexpected", 1, 0);
            end
        end
        prev_valid = res_valid;
    endtask

    task automatic model_update();
        logic       w;
        logic [2:0] op;
        m_granted = -1;
        if (rst) begin
            m_phase = 0; m_k = 0; m_full = '0; m_err = 1'b0; m_id = 1'b0;
            m_last = 1'b1; m_clean = 1'b1;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (req != 2'b00) begin
                    w = winner(req, m_last);
                    m_granted = int'(w);
                    m_last = w;
                    m_id = w;
                    m_clean = 1'b0;
                    op = w ? op1 : op0;
                    if (op > 3'd5) begin
                        m_err = 1'b1; m_full = '0; m_phase = 2;
                    end else begin
                        m_err = 1'b0; m_full = gate_word(op, w ? a1 : a0, w ? b1 : b0);
                        m_k = 0; m_phase = 1;
                    end
                    exp_q.push_back({m_id, m_err, m_full});
                end
                1: begin
                    m_k++;
                    if (m_k == WIDTH) m_phase = 2;
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
    endtask

    // driver tasks: inputs change at posedge+1, checks at negedge+1
    task automatic cycle();
        @(negedge clk);
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_until_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !seen_rise; i++) cycle();
        chk("valid_timeout", seen_rise, 1);
    endtask

    task automatic set_ops(input int i, input logic [2:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (i == 0) begin op0 = op; a0 = a; b0 = b; end
        else begin op1 = op; a1 = a; b1 = b; end
    endtask

    logic [7:0] sweep_exp [6];
    bit         pend [2];

    initial begin
        rst = 1'b1; req = 2'b00; res_ready = 1'b1;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // model pins
        chk("model_xnor", gate_word(3'd5, 8'h33, 8'h55), 8'h99);
        chk("model_nand", gate_word(3'd2, 8'hF0, 8'h3C), 8'hCF);
        chk("model_illegal", gate_word(3'd7, 8'hFF, 8'hFF), 8'h00);

        // single XOR request
        set_ops(0, 3'd4, 8'hF0, 8'h3C);
        req = 2'b01; seen_rise = 1'b0;
        cycle();
        req = 2'b00;
        run_until_valid(30);
        chk("xor_latency", rise_cyc - last_gnt_cyc, WIDTH + 1);
        chk("xor_result", res_q[$], 8'hCC);
        for (int i = 0; i < 3; i++) cycle();

        // contention alternates
        do_reset();
        set_ops(0, 3'd1, 8'hAA, 8'hFF);
        set_ops(1, 3'd3, 8'h0F, 8'h01);
        res_ready = 1'b1; gnt_q.delete(); res_q.delete();
        req = 2'b11;
        for (int i = 0; i < 35; i++) cycle();
        req = 2'b00;
        for (int i = 0; i < 12; i++) cycle();
        chk("rr_count", gnt_q.size() >= 3, 1);
        if (gnt_q.size() >= 3) begin
            chk("rr_g0", gnt_q[0], 2'b01);
            chk("rr_g1", gnt_q[1], 2'b10);
            chk("rr_g2", gnt_q[2], 2'b01);
        end
        chk("rr_res_count", res_q.size() >= 2, 1);
        if (res_q.size() >= 2) begin
            chk("rr_r0", res_q[0], 8'hAA);
            chk("rr_r1", res_q[1], 8'hF0);
        end

        // illegal opcode
        do_reset();
        set_ops(1, 3'd6, 8'hFF, 8'hFF);
        req = 2'b10; seen_rise = 1'b0;
        cycle();
        req = 2'b00;
        run_until_valid(5);
        chk("ill_latency", rise_cyc - last_gnt_cyc, 1);
        chk("ill_result", res_q[$], 8'h00);
        cycle();

        // back-pressure in DONE
        set_ops(0, 3'd0, 8'h5A, 8'hA5);
        set_ops(1, 3'd1, 8'hFF, 8'h0F);
        res_ready = 1'b0; seen_rise = 1'b0;
        req = 2'b01;
        cycle();
        req = 2'b11;
        run_until_valid(30);
        for (int i = 0; i < 4; i++) begin
            chk("stall_result", result, 8'hFF);
            chk("stall_busy", busy, 1);
            chk("stall_gnt", gnt, 0);
            cycle();
        end
        gnt_q.delete();
        res_ready = 1'b1;
        cycle();
        cycle();
        chk("after_accept_gnt", gnt_q.size() == 1 ? gnt_q[0] : 2'b11, 2'b10);
        req = 2'b00; seen_rise = 1'b0;
        run_until_valid(30);
        cycle();

        // reset in RUN cycle 3
        set_ops(1, 3'd0, 8'h12, 8'h34);
        req = 2'b10;
        cycle();
        req = 2'b00;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        cycle();
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_gnt", gnt, 0);
        rst = 1'b0;
        set_ops(1, 3'd4, 8'hF0, 8'h3C);
        req = 2'b10; seen_rise = 1'b0;
        cycle();
        req = 2'b00;
        run_until_valid(30);
        chk("rerun_latency", rise_cyc - last_gnt_cyc, WIDTH + 1);
        chk("rerun_result", res_q[$], 8'hCC);
        cycle();

        // opcode sweep
        sweep_exp[0] = 8'h77; sweep_exp[1] = 8'h11; sweep_exp[2] = 8'hEE;
        sweep_exp[3] = 8'h88; sweep_exp[4] = 8'h66; sweep_exp[5] = 8'h99;
        for (int op = 0; op < 6; op++) begin
            set_ops(0, 3'(op), 8'b0011_0011, 8'b0101_0101);
            req = 2'b01; seen_rise = 1'b0;
            cycle();
            req = 2'b00;
            run_until_valid(30);
            chk($sformatf("sweep_op%0d", op), res_q[$], sweep_exp[op]);
            cycle();
        end

        // random traffic
        pend[0] = 1'b0; pend[1] = 1'b0; req = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_granted == i) begin
                    pend[i] = 1'b0;
                    set_ops(i, 3'($urandom_range(7)), WIDTH'($urandom), WIDTH'($urandom));
                end else if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1'b1;
                    set_ops(i, 3'($urandom_range(7)), WIDTH'($urandom), WIDTH'($urandom));
                end
            end
            req = {pend[1], pend[0]};
            res_ready = 1'($urandom_range(1));
            rst = ($urandom_range(99) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        // final report
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
